// File: rtl/lcd_hd44780_responder_pkg.sv
// rtl/lcd_hd44780_responder_pkg.sv - shared opcodes, constants and helpers for the HD44780 responder
package lcd_hd44780_responder_pkg;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPCTL = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam int         DDRAM_DEPTH = 32;
  localparam logic [7:0] ROW1_BASE   = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    I_NOP, I_CLEAR, I_HOME, I_ENTRY, I_DISPCTL, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
  } instr_e;

  // The instruction class is the highest set bit of the byte.
  function automatic instr_e classify(input logic [7:0] d);
    instr_e r;
    if      ((d & OP_DDRAM)   != 8'h00) r = I_DDRAM;
    else if ((d & OP_CGRAM)   != 8'h00) r = I_CGRAM;
    else if ((d & OP_FUNC)    != 8'h00) r = I_FUNC;
    else if ((d & OP_SHIFT)   != 8'h00) r = I_SHIFT;
    else if ((d & OP_DISPCTL) != 8'h00) r = I_DISPCTL;
    else if ((d & OP_ENTRY)   != 8'h00) r = I_ENTRY;
    else if ((d & OP_HOME)    != 8'h00) r = I_HOME;
    else if ((d & OP_CLEAR)   != 8'h00) r = I_CLEAR;
    else                                r = I_NOP;
    return r;
  endfunction

  // 5-bit arithmetic gives the 31<->0 wrap for free.
  function automatic logic [4:0] cursor_step(input logic [4:0] cur, input logic inc);
    return inc ? cur + 5'd1 : cur - 5'd1;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_sync.sv
// rtl/lcd_hd44780_responder_sync.sv - 2-FF synchronizers and registered E falling-edge strobe
module lcd_bus_sync
  import lcd_hd44780_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       e_i,
  input  logic       rs_i,
  input  logic       rw_i,
  input  logic [7:0] d_i,
  output logic       strobe_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] d_o
);

  logic       e_s1_q, e_s2_q, e_s3_q;
  logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
  logic [7:0] d_s1_q, d_s2_q;
  logic       strobe_q, rs_q, rw_q;
  logic [7:0] d_q;

  // Bus fields are delayed alongside the strobe so the consumer sees them in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_s1_q   <= 1'b0;
      e_s2_q   <= 1'b0;
      e_s3_q   <= 1'b0;
      rs_s1_q  <= 1'b0;
      rs_s2_q  <= 1'b0;
      rw_s1_q  <= 1'b0;
      rw_s2_q  <= 1'b0;
      d_s1_q   <= 8'h00;
      d_s2_q   <= 8'h00;
      strobe_q <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      d_q      <= 8'h00;
    end else begin
      e_s1_q   <= e_i;
      e_s2_q   <= e_s1_q;
      e_s3_q   <= e_s2_q;
      rs_s1_q  <= rs_i;
      rs_s2_q  <= rs_s1_q;
      rw_s1_q  <= rw_i;
      rw_s2_q  <= rw_s1_q;
      d_s1_q   <= d_i;
      d_s2_q   <= d_s1_q;
      strobe_q <= e_s3_q & ~e_s2_q;
      rs_q     <= rs_s2_q;
      rw_q     <= rw_s2_q;
      d_q      <= d_s2_q;
    end
  end

  assign strobe_o = strobe_q;
  assign rs_o     = rs_q;
  assign rw_o     = rw_q;
  assign d_o      = d_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780 write-side responder with DDRAM shadow and busy model
module lcd_hd44780_responder
  import lcd_hd44780_responder_pkg::*;
#(
  parameter int   CLK_HZ        = 40000000,
  parameter logic SIM_SPEEDUP   = 1'b0,
  parameter int   BUSY_SHORT_US = 40,
  parameter int   BUSY_LONG_US  = 1640
) (
  input  logic       clk_40MHz,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_d,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cursor_addr,
  output logic       display_on,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       data_valid,
  output logic       err_busy,
  output logic       err_addr
);

  localparam int CYC_PER_US = CLK_HZ / 1000000;
  localparam int SHORT_RAW  = CYC_PER_US * BUSY_SHORT_US;
  localparam int LONG_RAW   = CYC_PER_US * BUSY_LONG_US;
  localparam int SHORT_N    = SIM_SPEEDUP ? SHORT_RAW / 100 : SHORT_RAW;
  localparam int LONG_N     = SIM_SPEEDUP ? LONG_RAW / 100 : LONG_RAW;
  localparam logic [16:0] SHORT_CNT = SHORT_N[16:0];
  localparam logic [16:0] LONG_CNT  = LONG_N[16:0];

  logic       strobe, s_rs, s_rw;
  logic [7:0] s_d;
  instr_e     instr;

  lcd_bus_sync u_sync (
    .clk_i    (clk_40MHz),
    .rst_i    (reset),
    .e_i      (lcd_e),
    .rs_i     (lcd_rs),
    .rw_i     (lcd_rw),
    .d_i      (lcd_d),
    .strobe_o (strobe),
    .rs_o     (s_rs),
    .rw_o     (s_rw),
    .d_o      (s_d)
  );

  always_comb begin
    instr = classify(s_d);
  end

  state_e      state_q;
  logic [7:0]  ddram_q [DDRAM_DEPTH];
  logic [4:0]  cursor_q, clr_idx_q;
  logic        id_q, disp_q, busy_q;
  logic [16:0] cnt_q;
  logic [7:0]  rd_data_q, cmd_code_q;
  logic        cmd_valid_q, data_valid_q, err_busy_q, err_addr_q;

  always_ff @(posedge clk_40MHz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < DDRAM_DEPTH; i++) ddram_q[i] <= CHAR_SPACE;
      cursor_q     <= 5'd0;
      clr_idx_q    <= 5'd0;
      id_q         <= 1'b1;
      disp_q       <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= 17'd0;
      rd_data_q    <= 8'h00;
      cmd_code_q   <= 8'h00;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      err_busy_q   <= 1'b0;
      err_addr_q   <= 1'b0;
    end else begin
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      err_busy_q   <= 1'b0;
      err_addr_q   <= 1'b0;
      rd_data_q    <= ddram_q[rd_addr];

      case (state_q)
        ST_IDLE: begin
          if (strobe && !s_rw) begin
            busy_q  <= 1'b1;
            cnt_q   <= SHORT_CNT;
            state_q <= ST_BUSY;
            if (s_rs) begin
              ddram_q[cursor_q] <= s_d;
              data_valid_q      <= 1'b1;
              cursor_q          <= cursor_step(cursor_q, id_q);
            end else begin
              cmd_valid_q <= 1'b1;
              cmd_code_q  <= s_d;
              case (instr)
                I_DDRAM: begin
                  if (s_d[6:4] == 3'b000)
                    cursor_q <= {1'b0, s_d[3:0]};
                  else if (s_d[6:4] == ROW1_BASE[6:4])
                    cursor_q <= {1'b1, s_d[3:0]};
                  else
                    err_addr_q <= 1'b1;
                end
                I_SHIFT: begin
                  if (!s_d[3]) cursor_q <= cursor_step(cursor_q, s_d[2]);
                end
                I_DISPCTL: disp_q <= s_d[2];
                I_ENTRY:   id_q   <= s_d[1];
                I_HOME: begin
                  cursor_q <= 5'd0;
                  cnt_q    <= LONG_CNT;
                end
                I_CLEAR: begin
                  cursor_q  <= 5'd0;
                  id_q      <= 1'b1;
                  clr_idx_q <= 5'd0;
                  cnt_q     <= LONG_CNT;
                  state_q   <= ST_CLEAR;
                end
                default: ;
              endcase
            end
          end
        end

        // The long count keeps running through the sweep, so BUSY only absorbs the remainder.
        ST_CLEAR: begin
          if (strobe) err_busy_q <= 1'b1;
          ddram_q[clr_idx_q] <= CHAR_SPACE;
          clr_idx_q          <= clr_idx_q + 5'd1;
          cnt_q              <= cnt_q - 17'd1;
          if (clr_idx_q == 5'(DDRAM_DEPTH - 1)) state_q <= ST_BUSY;
        end

        ST_BUSY: begin
          if (strobe) err_busy_q <= 1'b1;
          if (cnt_q <= 17'd1) begin
            cnt_q   <= 17'd0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 17'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign busy        = busy_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign data_valid  = data_valid_q;
  assign err_busy    = err_busy_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb/tb_lcd_hd44780_responder.sv - directed and randomized check of the HD44780 responder against a model
module tb_lcd_hd44780_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_rs = 1'b0, lcd_e = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_d = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data, cmd_code;
  logic [4:0] cursor_addr;
  logic       display_on, busy, cmd_valid, data_valid, err_busy, err_addr;

  always #5 clk = ~clk;

  lcd_hd44780_responder #(.SIM_SPEEDUP(1'b1)) dut (
    .clk_40MHz   (clk),
    .reset       (reset),
    .lcd_rs      (lcd_rs),
    .lcd_e       (lcd_e),
    .lcd_rw      (lcd_rw),
    .lcd_d       (lcd_d),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .cursor_addr (cursor_addr),
    .display_on  (display_on),
    .busy        (busy),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .data_valid  (data_valid),
    .err_busy    (err_busy),
    .err_addr    (err_addr)
  );

  int total = 0;
  int bad = 0;

  int n_cmd = 0, n_data = 0, n_ebusy = 0, n_eaddr = 0;
  logic [7:0] last_code = 8'h00;
  int busy_run = 0, busy_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (cmd_valid) begin n_cmd++; last_code = cmd_code; end
      if (data_valid) n_data++;
      if (err_busy) n_ebusy++;
      if (err_addr) n_eaddr++;
      if (busy) busy_run++;
      else if (busy_run > 0) begin busy_len = busy_run; busy_run = 0; end
    end
  end

  // Reference model: what the display should hold after each accepted transfer
  logic [7:0] m_mem [32];
  int m_cur;
  bit m_id, m_disp;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_cur = 0; m_id = 1'b1; m_disp = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_d = d; lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic read_byte(input int a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a[4:0];
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic check_mem(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_byte(i, v);
      chk($sformatf("%s_ddram%0d", tag, i), {24'd0, v}, {24'd0, m_mem[i]});
    end
  endtask

  task automatic op(input bit rs, input logic [7:0] d);
    int c0, d0, e0;
    bit exp_err, is_long;
    int dv;
    c0 = n_cmd; d0 = n_data; e0 = n_eaddr;
    exp_err = 0; is_long = 0; dv = d;
    xfer(rs, 1'b0, d);
    wait_idle(1000);
    if (rs) begin
      m_mem[m_cur] = d;
      m_cur = (m_cur + (m_id ? 1 : 31)) % 32;
    end else if (dv >= 'h80) begin
      if (dv <= 'h8F) m_cur = dv - 'h80;
      else if (dv >= 'hC0 && dv <= 'hCF) m_cur = dv - 'hC0 + 16;
      else exp_err = 1;
    end else if (dv >= 'h20) begin
    end else if (dv >= 'h10) begin
      if (dv < 'h18) m_cur = (m_cur + ((dv >= 'h14) ? 1 : 31)) % 32;
    end else if (dv >= 'h08) begin
      m_disp = (dv >= 'h0C);
    end else if (dv >= 'h04) begin
      m_id = (dv >= 'h06);
    end else if (dv >= 'h02) begin
      m_cur = 0; is_long = 1;
    end else if (dv == 'h01) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_cur = 0; m_id = 1'b1; is_long = 1;
    end
    chk($sformatf("cmd_pulses_%0h", d), n_cmd - c0, rs ? 0 : 1);
    chk($sformatf("data_pulses_%0h", d), n_data - d0, rs ? 1 : 0);
    chk($sformatf("err_addr_%0h", d), n_eaddr - e0, exp_err);
    if (!rs) chk($sformatf("cmd_code_%0h", d), {24'd0, last_code}, {24'd0, d});
    chk($sformatf("busy_len_%0h", d), busy_len, is_long ? 656 : 16);
    chk($sformatf("cursor_%0h", d), {27'd0, cursor_addr}, m_cur);
    chk($sformatf("display_on_%0h", d), {31'd0, display_on}, {31'd0, m_disp});
  endtask

  initial begin
    int c0, d0, e0, b0, k;
    logic [7:0] rv;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cursor", {27'd0, cursor_addr}, 32'd0);
    chk("rst_display_on", {31'd0, display_on}, 32'd0);
    check_mem("rst");

    // Display on, home position, two characters
    op(0, 8'h0C);
    op(0, 8'h80);
    op(1, 8'h57);
    op(1, 8'h4F);
    check_mem("wo");

    // Row 1 addressing, decrement mode, cursor-left wrap
    op(0, 8'hC5);
    op(1, 8'h31);
    op(0, 8'h04);
    op(1, 8'h32);
    op(0, 8'h80);
    op(0, 8'h10);
    check_mem("row1");

    // Fill then clear, with a data strobe landing inside the sweep
    op(0, 8'h06);
    op(0, 8'h80);
    for (int i = 0; i < 32; i++) op(1, 8'h41);
    c0 = n_cmd; d0 = n_data; b0 = n_ebusy;
    xfer(0, 1'b0, 8'h01);
    xfer(1, 1'b0, 8'h58);
    wait_idle(1000);
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_cur = 0; m_id = 1'b1;
    chk("clr_cmd_pulses", n_cmd - c0, 1);
    chk("clr_data_discarded", n_data - d0, 0);
    chk("clr_err_busy", n_ebusy - b0, 1);
    chk("clr_busy_len", busy_len, 656);
    chk("clr_cursor", {27'd0, cursor_addr}, 32'd0);
    check_mem("clr");

    // Out-of-range set-DDRAM, then a read strobe
    op(1, 8'h61);
    op(0, 8'h95);
    c0 = n_cmd; d0 = n_data; e0 = n_eaddr; b0 = n_ebusy;
    xfer(0, 1'b1, 8'h01);
    repeat (4) @(negedge clk);
    chk("rw_no_cmd", n_cmd - c0, 0);
    chk("rw_no_data", n_data - d0, 0);
    chk("rw_no_err", (n_eaddr - e0) + (n_ebusy - b0), 0);
    chk("rw_no_busy", {31'd0, busy}, 32'd0);
    chk("rw_cursor", {27'd0, cursor_addr}, m_cur);
    check_mem("rw");

    // Reset in the middle of the clear sweep
    op(0, 8'h0F);
    xfer(0, 1'b0, 8'h01);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midclr_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midclr_cursor", {27'd0, cursor_addr}, 32'd0);
    chk("midclr_display", {31'd0, display_on}, 32'd0);
    check_mem("midclr");
    op(1, 8'h42);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: op(1, 8'($urandom_range(8'h20, 8'h7E)));
        3:       op(0, ($urandom_range(0, 1) ? 8'h80 : 8'hC0) | 8'($urandom_range(0, 15)));
        4:       op(0, 8'($urandom_range(8'h20, 8'hFF)));
        5:       op(0, 8'($urandom_range(8'h10, 8'h1F)));
        6:       op(0, 8'($urandom_range(8'h08, 8'h0F)));
        7:       op(0, 8'($urandom_range(8'h04, 8'h07)));
        8:       op(0, 8'($urandom_range(8'h02, 8'h03)));
        default: op(0, 8'h00);
      endcase
    end
    check_mem("rand");
    read_byte(0, rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
